equ_ctrl: RTL

- One-tap frequency-domain channel equalizer controller for the NB-IoT uplink receiver.
- Owns the write and read sides of the 12-entry channel-estimate RAM (12 x 32-bit, registered read, one write port).
- Per slot: first loads 12 channel estimates H[k] from the estimator, then streams NUM_DATA_SYM data symbols of 12 subcarriers each.
- For every data sample it outputs Y[k]*conj(H[k]) to the demapper.

---
 rtl/equ_pkg.sv | 47 ++++
 rtl/cmult_conj.sv | 35 +++
 rtl/equ_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/equ_pkg.sv
// Shared types, constants and the component-reduction helper for the one-tap equalizer.
package equ_pkg;

  localparam int DATA_WIDTH        = 16;
  localparam int DOUBLE_DATA_WIDTH = 32;
  localparam int NUM_SC            = 12;
  localparam int ADDR_WIDTH        = 4;
  localparam int NUM_DATA_SYM      = 6;
  localparam int SYM_CNT_WIDTH     = 3;
  localparam int PROD_WIDTH        = 2 * DATA_WIDTH;
  localparam int SUM_WIDTH         = PROD_WIDTH + 1;
  localparam int SHR_WIDTH         = SUM_WIDTH - (DATA_WIDTH - 1);

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_H   = 2'd1,
    EQUALIZE = 2'd2
  } equ_state_t;

  // Q2.30 sum -> Q1.15: floor shift, then either clamp or keep the low bits.
  function automatic logic [DATA_WIDTH-1:0] reduce_comp(input logic [SUM_WIDTH-1:0] s,
                                                        input logic                 sat_en);
    logic [SHR_WIDTH-1:0] v;
    logic                 ovf;
    v   = s[SUM_WIDTH-1:DATA_WIDTH-1];
    ovf = (v[SHR_WIDTH-1:DATA_WIDTH-1] != {(SHR_WIDTH-DATA_WIDTH+1){v[DATA_WIDTH-1]}});
    if (sat_en && ovf)
      reduce_comp = v[SHR_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      reduce_comp = v[DATA_WIDTH-1:0];
  endfunction

  function automatic cplx_t pack_cplx(input logic [DATA_WIDTH-1:0] re,
                                      input logic [DATA_WIDTH-1:0] im);
    cplx_t z;
    z.re = re;
    z.im = im;
    return z;
  endfunction

endpackage

// File: rtl/cmult_conj.sv
// Combinational Y*conj(H) with Q1.15 rescale.
// EQU_SAT_EN defined: components saturate on overflow; undefined: two's-complement wrap.
module cmult_conj
  import equ_pkg::*;
(
  input  logic [DOUBLE_DATA_WIDTH-1:0] i_y,
  input  logic [DOUBLE_DATA_WIDTH-1:0] i_h,
  output logic [DOUBLE_DATA_WIDTH-1:0] o_z
);

`ifdef EQU_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  cplx_t                        y;
  cplx_t                        h;
  logic signed [PROD_WIDTH-1:0] ac, bd, bc, ad;
  logic signed [SUM_WIDTH-1:0]  re_sum, im_sum;

  assign y = i_y;
  assign h = i_h;

  assign ac = PROD_WIDTH'(y.re) * PROD_WIDTH'(h.re);
  assign bd = PROD_WIDTH'(y.im) * PROD_WIDTH'(h.im);
  assign bc = PROD_WIDTH'(y.im) * PROD_WIDTH'(h.re);
  assign ad = PROD_WIDTH'(y.re) * PROD_WIDTH'(h.im);

  assign re_sum = SUM_WIDTH'(ac) + SUM_WIDTH'(bd);
  assign im_sum = SUM_WIDTH'(bc) - SUM_WIDTH'(ad);

  assign o_z = pack_cplx(reduce_comp(re_sum, SAT_EN), reduce_comp(im_sum, SAT_EN));

endmodule

// File: rtl/equ_ctrl.sv
// One-tap channel equalizer controller: loads NUM_SC estimates into the H RAM, then
// equalizes NUM_DATA_SYM symbols against them with a two-cycle accept-to-output latency.
module equ_ctrl
  import equ_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_est_valid,
  input  logic [DOUBLE_DATA_WIDTH-1:0] i_est_data,
  output logic                         o_est_ready,
  input  logic                         i_sym_valid,
  input  logic [DOUBLE_DATA_WIDTH-1:0] i_sym_data,
  output logic                         o_sym_ready,
  output logic                         o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0]        o_ram_wr_add,
  output logic [DOUBLE_DATA_WIDTH-1:0] o_ram_wr_data,
  output logic [ADDR_WIDTH-1:0]        o_ram_rd_add,
  input  logic [DOUBLE_DATA_WIDTH-1:0] i_ram_rd_data,
  output logic                         o_equ_valid,
  output logic [DOUBLE_DATA_WIDTH-1:0] o_equ_data,
  output logic                         o_sym_done,
  output logic                         o_slot_done,
  output logic                         o_busy
);

  // state    | meaning
  // IDLE     | waiting for H[0]
  // LOAD_H   | writing H[1..NUM_SC-1]
  // EQUALIZE | streaming data samples against the stored H

  equ_state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]        sc_cnt_q, sc_cnt_d;
  logic [SYM_CNT_WIDTH-1:0]     sym_cnt_q, sym_cnt_d;
  logic [DOUBLE_DATA_WIDTH-1:0] y_q, y_d;
  logic                         s1_valid_q, s1_valid_d;
  logic                         s1_sym_last_q, s1_sym_last_d;
  logic                         s1_slot_last_q, s1_slot_last_d;
  logic                         equ_valid_q, equ_valid_d;
  logic [DOUBLE_DATA_WIDTH-1:0] equ_data_q, equ_data_d;
  logic                         sym_done_q, sym_done_d;
  logic                         slot_done_q, slot_done_d;
  logic                         est_hs, sym_hs;
  logic [DOUBLE_DATA_WIDTH-1:0] z;

  // Gating with i_rst_n keeps est_ready low while reset is held.
  assign o_est_ready = i_rst_n & ((state_q == IDLE) | (state_q == LOAD_H));
  assign o_sym_ready = (state_q == EQUALIZE);
  assign est_hs      = i_est_valid & o_est_ready;
  assign sym_hs      = i_sym_valid & o_sym_ready;
  assign o_busy      = (state_q != IDLE);

  cmult_conj u_cmult (
    .i_y (y_q),
    .i_h (i_ram_rd_data),
    .o_z (z)
  );

  always_comb begin
    state_d        = state_q;
    sc_cnt_d       = sc_cnt_q;
    sym_cnt_d      = sym_cnt_q;
    y_d            = y_q;
    s1_valid_d     = 1'b0;
    s1_sym_last_d  = 1'b0;
    s1_slot_last_d = 1'b0;
    o_ram_wr_en    = 1'b0;
    o_ram_wr_add   = '0;
    o_ram_wr_data  = '0;
    o_ram_rd_add   = '0;
    case (state_q)
      IDLE: begin
        if (est_hs) begin
          o_ram_wr_en   = 1'b1;
          o_ram_wr_data = i_est_data;
          sc_cnt_d      = ADDR_WIDTH'(1);
          state_d       = LOAD_H;
        end
      end
      LOAD_H: begin
        if (est_hs) begin
          o_ram_wr_en   = 1'b1;
          o_ram_wr_add  = sc_cnt_q;
          o_ram_wr_data = i_est_data;
          if (sc_cnt_q == ADDR_WIDTH'(NUM_SC - 1)) begin
            sc_cnt_d = '0;
            state_d  = EQUALIZE;
          end else begin
            sc_cnt_d = sc_cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      EQUALIZE: begin
        o_ram_rd_add = sc_cnt_q;
        if (sym_hs) begin
          y_d        = i_sym_data;
          s1_valid_d = 1'b1;
          if (sc_cnt_q == ADDR_WIDTH'(NUM_SC - 1)) begin
            sc_cnt_d      = '0;
            s1_sym_last_d = 1'b1;
            if (sym_cnt_q == SYM_CNT_WIDTH'(NUM_DATA_SYM - 1)) begin
              sym_cnt_d      = '0;
              s1_slot_last_d = 1'b1;
              state_d        = IDLE;
            end else begin
              sym_cnt_d = sym_cnt_q + SYM_CNT_WIDTH'(1);
            end
          end else begin
            sc_cnt_d = sc_cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    equ_valid_d = s1_valid_q;
    equ_data_d  = s1_valid_q ? z : '0;
    sym_done_d  = s1_sym_last_q;
    slot_done_d = s1_slot_last_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      sc_cnt_q       <= '0;
      sym_cnt_q      <= '0;
      y_q            <= '0;
      s1_valid_q     <= 1'b0;
      s1_sym_last_q  <= 1'b0;
      s1_slot_last_q <= 1'b0;
      equ_valid_q    <= 1'b0;
      equ_data_q     <= '0;
      sym_done_q     <= 1'b0;
      slot_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sc_cnt_q       <= sc_cnt_d;
      sym_cnt_q      <= sym_cnt_d;
      y_q            <= y_d;
      s1_valid_q     <= s1_valid_d;
      s1_sym_last_q  <= s1_sym_last_d;
      s1_slot_last_q <= s1_slot_last_d;
      equ_valid_q    <= equ_valid_d;
      equ_data_q     <= equ_data_d;
      sym_done_q     <= sym_done_d;
      slot_done_q    <= slot_done_d;
    end
  end

  assign o_equ_valid = equ_valid_q;
  assign o_equ_data  = equ_data_q;
  assign o_sym_done  = sym_done_q;
  assign o_slot_done = slot_done_q;

endmodule
